// File: rtl/alu_result_serializer.sv
// Buffers ALU results (+carry) in a small FIFO and streams each one out as a little-endian byte frame.
// Optional: define ALU_SER_PARITY_EN to add the Out_Parity output (even parity of Out_Data).
module alu_result_serializer #(
    parameter int RES_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [RES_WIDTH-1:0]          Res_In,
    input  logic                          Carry_In,
    input  logic                          Res_Valid,
    output logic [7:0]                    Out_Data,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic                          Out_Last,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
    output logic                          Overflow,
    input  logic                          Ovf_Clr,
`ifdef ALU_SER_PARITY_EN
    output logic                          Out_Parity,
`endif
    output logic                          Busy
);
    localparam int NB    = RES_WIDTH / 8 + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NB);
    localparam int FRM_W = 8 * NB;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [RES_WIDTH:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_ovf;

    state_t              r_state;
    logic [FRM_W-1:0]    r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_par;

    logic                w_empty;
    logic                w_full;
    logic                w_hs;
    logic                w_frame_end;
    logic                w_adv;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [FRM_W-1:0]    w_frame;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_hs        = r_valid & Out_Ready;
    assign w_frame_end = w_hs & (r_idx == IDX_W'(NB - 1));
    assign w_adv       = w_hs & ~w_frame_end;
    // Pop when idle, or on the last byte's handshake so frames run back to back.
    assign w_pop       = ~w_empty & ((r_state == S_IDLE) | w_frame_end);
    assign w_push      = Res_Valid & (~w_full | w_pop);
    assign w_drop      = Res_Valid & w_full & ~w_pop;
    assign w_frame     = {7'b0, r_mem[r_rd_ptr]};

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {Carry_In, Res_In};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LVL_W'(1);
            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (Ovf_Clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_par   <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_SEND;
            r_data  <= w_frame[7:0];
            r_par   <= ^w_frame[7:0];
            r_shift <= w_frame >> 8;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (w_adv) begin
            r_data  <= r_shift[7:0];
            r_par   <= ^r_shift[7:0];
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + IDX_W'(1);
            r_last  <= (r_idx == IDX_W'(NB - 2));
        end else if (w_frame_end) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign Out_Data   = r_data;
    assign Out_Valid  = r_valid;
    assign Out_Last   = r_last;
    assign Fifo_Level = r_level;
    assign Overflow   = r_ovf;
    assign Busy       = (r_level != '0) | r_valid;
`ifdef ALU_SER_PARITY_EN
    assign Out_Parity = r_par;
`endif

endmodule
